// File: rtl/v_hier_pkg.sv
// Shared definitions for the v_hier data leaf.
//   mode_t    : 2-bit operating mode of the sub-array
//   MODE_*    : encodings for pass, invert, hold and tie
package v_hier_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_PASS = 2'd0;
    localparam mode_t MODE_INV  = 2'd1;
    localparam mode_t MODE_HOLD = 2'd2;
    localparam mode_t MODE_TIE  = 2'd3;

endpackage

// File: rtl/v_hier_subarray_if.sv
// Bus bundle between the hierarchy top (master) and the v_hier_subarray
// data leaf (slave).
//   avec/en/mode/clr : master -> leaf, sample data, sample valid, mode, counter clear
//   qvec/qvalid      : leaf -> master, last pipeline stage data and valid
//   chg_cnt          : leaf -> master, saturating count of valid output changes
interface v_hier_subarray_if
    import v_hier_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNTW  = 8
);
    logic [WIDTH-1:0] avec;
    logic             en;
    mode_t            mode;
    logic             clr;
    logic [WIDTH-1:0] qvec;
    logic             qvalid;
    logic [CNTW-1:0]  chg_cnt;

    modport master (
        output avec, en, mode, clr,
        input  qvec, qvalid, chg_cnt
    );

    modport slave (
        input  avec, en, mode, clr,
        output qvec, qvalid, chg_cnt
    );
endinterface

// File: rtl/v_hier_subcell.sv
// One channel of the sub-array: a DEPTH-stage 1-bit shift register.
//   clk, reset : clock and asynchronous active-high reset
//   advance    : shift enable; when low every stage keeps its value
//   d          : bit loaded into stage 0 on an advancing edge
//   pre        : bit that the last stage will load on the next advancing edge
//   q          : last stage
module v_hier_subcell #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic advance,
    input  logic d,
    output logic pre,
    output logic q
);
    logic [DEPTH-1:0] stage_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_reg <= '0;
        end else if (advance) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                stage_reg[k] <= stage_reg[k-1];
            end
            stage_reg[0] <= d;
        end
    end

    // With a single stage the last stage is fed straight from d.
    generate
        if (DEPTH == 1) begin : g_pre_d
            assign pre = d;
        end else begin : g_pre_stage
            assign pre = stage_reg[DEPTH-2];
        end
    endgenerate

    assign q = stage_reg[DEPTH-1];
endmodule

// File: rtl/v_hier_subarray.sv
// Parametrised data leaf: WIDTH channels, each a DEPTH-stage registered
// pipeline, with a mode mux in front, a valid pipe alongside and a
// saturating counter of valid output changes.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : slave side of v_hier_subarray_if (avec, en, mode, clr in;
//                qvec, qvalid, chg_cnt out)
module v_hier_subarray
    import v_hier_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter int               DEPTH   = 2,
    parameter int               CNTW    = 8,
    parameter logic [WIDTH-1:0] TIE_VAL = {WIDTH{1'b1}}
) (
    input  logic               clk,
    input  logic               reset,
    v_hier_subarray_if.slave   bus
);
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic             advance;
    logic [WIDTH-1:0] stage0_d;
    logic [WIDTH-1:0] pre_d;
    logic [WIDTH-1:0] q_d;
    logic [DEPTH-1:0] valid_reg;
    logic             pre_valid;
    logic [CNTW-1:0]  cnt_reg;
    logic [CNTW-1:0]  cnt_next;

    // HOLD freezes everything; the other modes only pick what enters stage 0.
    always_comb begin
        advance  = (bus.mode != MODE_HOLD);
        stage0_d = bus.avec;
        case (bus.mode)
            MODE_INV: stage0_d = ~bus.avec;
            MODE_TIE: stage0_d = TIE_VAL;
            default:  stage0_d = bus.avec;
        endcase
    end

    // Channel 0 is connected by name and channel 2 by position so the
    // hierarchy parser sees both styles.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
            if (gi == 2) begin : g_positional
                v_hier_subcell #(DEPTH) u_cell (clk, reset, advance, stage0_d[gi], pre_d[gi], q_d[gi]);
            end else begin : g_named
                v_hier_subcell #(.DEPTH(DEPTH)) u_cell (
                    .clk     (clk),
                    .reset   (reset),
                    .advance (advance),
                    .d       (stage0_d[gi]),
                    .pre     (pre_d[gi]),
                    .q       (q_d[gi])
                );
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= '0;
        end else if (advance) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                valid_reg[k] <= valid_reg[k-1];
            end
            valid_reg[0] <= bus.en;
        end
    end

    generate
        if (DEPTH == 1) begin : g_pre_valid_en
            assign pre_valid = bus.en;
        end else begin : g_pre_valid_stage
            assign pre_valid = valid_reg[DEPTH-2];
        end
    endgenerate

    // Count an edge where a valid sample replaces a different qvec value.
    always_comb begin
        cnt_next = cnt_reg;
        if (bus.clr) begin
            cnt_next = '0;
        end else if (advance && pre_valid && (pre_d != q_d) && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign bus.qvec    = q_d;
    assign bus.qvalid  = valid_reg[DEPTH-1];
    assign bus.chg_cnt = cnt_reg;
endmodule

// File: tb/tb_v_hier_subarray.sv
// Bench for v_hier_subarray: two instances (default parameters, and
// DEPTH=3/CNTW=2) share one stimulus stream. Each is compared every cycle
// against a queue model of the samples in flight, plus directed checks.
module tb_v_hier_subarray;
    import v_hier_pkg::*;

    typedef struct packed {
        logic [3:0] d;
        logic       v;
    } ent_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] avec;
    logic       en;
    logic [1:0] mode;
    logic       clr;

    int checks = 0;
    int passed = 0;

    ent_t pa[$];
    ent_t pb[$];
    int   ca;
    int   cb;

    always #5 clk = ~clk;

    v_hier_subarray_if #(.WIDTH(4), .CNTW(8)) bus_a ();
    v_hier_subarray_if #(.WIDTH(4), .CNTW(2)) bus_b ();

    assign bus_a.avec = avec;
    assign bus_a.en   = en;
    assign bus_a.mode = mode;
    assign bus_a.clr  = clr;
    assign bus_b.avec = avec;
    assign bus_b.en   = en;
    assign bus_b.mode = mode;
    assign bus_b.clr  = clr;

    v_hier_subarray #(.WIDTH(4), .DEPTH(2), .CNTW(8)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    v_hier_subarray #(.WIDTH(4), .DEPTH(3), .CNTW(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // The pipe is a queue of in-flight samples, oldest (the output) first.
    task automatic model_reset();
        pa.delete();
        pb.delete();
        repeat (2) pa.push_back('0);
        repeat (3) pb.push_back('0);
        ca = 0;
        cb = 0;
    endtask

    task automatic mstep(inout ent_t pipe[$], inout int cnt, input int cmax);
        ent_t old_out;
        ent_t ne;
        old_out = pipe[0];
        if (mode != MODE_HOLD) begin
            ne.d = (mode == MODE_PASS) ? avec : (mode == MODE_INV) ? ~avec : 4'hF;
            ne.v = en;
            pipe.push_back(ne);
            ne = pipe.pop_front();
            if (pipe[0].v && pipe[0].d != old_out.d && cnt < cmax) cnt++;
        end
        if (clr) cnt = 0;
    endtask

    task automatic compare_all();
        chk("a_qvec",   32'(bus_a.qvec),    32'(pa[0].d));
        chk("a_qvalid", 32'(bus_a.qvalid),  32'(pa[0].v));
        chk("a_cnt",    32'(bus_a.chg_cnt), 32'(ca));
        chk("b_qvec",   32'(bus_b.qvec),    32'(pb[0].d));
        chk("b_qvalid", 32'(bus_b.qvalid),  32'(pb[0].v));
        chk("b_cnt",    32'(bus_b.chg_cnt), 32'(cb));
    endtask

    task automatic tick();
        mstep(pa, ca, 255);
        mstep(pb, cb, 3);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic drive(input logic [1:0] m, input logic [3:0] a, input logic e, input logic c);
        mode = m;
        avec = a;
        en   = e;
        clr  = c;
    endtask

    initial begin
        reset = 1'b1;
        drive(MODE_PASS, 4'h0, 1'b0, 1'b0);
        model_reset();
        #1;
        chk("rst_a_qvec", 32'(bus_a.qvec), 32'h0);
        chk("rst_a_qvalid", 32'(bus_a.qvalid), 32'h0);
        chk("rst_a_cnt", 32'(bus_a.chg_cnt), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // PASS A then 5: A appears two edges after it enters.
        drive(MODE_PASS, 4'hA, 1'b1, 1'b0); tick();
        drive(MODE_PASS, 4'h5, 1'b1, 1'b0); tick();
        chk("pass_first", 32'(bus_a.qvec), 32'hA);
        chk("pass_first_v", 32'(bus_a.qvalid), 32'h1);
        drive(MODE_PASS, 4'h0, 1'b0, 1'b0); tick();
        chk("pass_second", 32'(bus_a.qvec), 32'h5);
        chk("pass_cnt", 32'(bus_a.chg_cnt), 32'h2);
        tick();
        tick();

        // INV of 3 held for three cycles counts a single change.
        drive(MODE_INV, 4'h3, 1'b1, 1'b0);
        repeat (3) tick();
        chk("inv_q", 32'(bus_a.qvec), 32'hC);
        chk("inv_v", 32'(bus_a.qvalid), 32'h1);
        chk("inv_cnt", 32'(bus_a.chg_cnt), 32'h3);

        // Stream 1,2, HOLD two cycles, then 3.
        drive(MODE_PASS, 4'h1, 1'b1, 1'b0); tick();
        drive(MODE_PASS, 4'h2, 1'b1, 1'b0); tick();
        drive(MODE_HOLD, 4'h7, 1'b1, 1'b0); tick(); tick();
        chk("hold_q", 32'(bus_a.qvec), 32'h1);
        chk("hold_cnt", 32'(bus_a.chg_cnt), 32'h4);
        drive(MODE_PASS, 4'h3, 1'b1, 1'b0); tick();
        chk("resume_q2", 32'(bus_a.qvec), 32'h2);
        drive(MODE_PASS, 4'h0, 1'b0, 1'b0); tick();
        chk("resume_q3", 32'(bus_a.qvec), 32'h3);
        tick();
        chk("invalid_v", 32'(bus_a.qvalid), 32'h0);
        chk("invalid_cnt", 32'(bus_a.chg_cnt), 32'h6);

        // Saturation on the CNTW=2 instance, then clr against an increment.
        drive(MODE_PASS, 4'h0, 1'b0, 1'b1); tick();
        drive(MODE_PASS, 4'h0, 1'b0, 1'b0); repeat (3) tick();
        for (int i = 0; i < 7; i++) begin
            drive(MODE_PASS, (i % 2 == 0) ? 4'hA : 4'h5, 1'b1, 1'b0);
            tick();
        end
        chk("sat_cnt", 32'(bus_b.chg_cnt), 32'h3);
        drive(MODE_PASS, 4'h5, 1'b1, 1'b1); tick();
        chk("clr_prio", 32'(bus_b.chg_cnt), 32'h0);

        // Asynchronous reset with the pipe full, between edges.
        drive(MODE_PASS, 4'h9, 1'b1, 1'b0);
        repeat (3) tick();
        #3;
        reset = 1'b1;
        #1;
        chk("arst_a_q", 32'(bus_a.qvec), 32'h0);
        chk("arst_a_v", 32'(bus_a.qvalid), 32'h0);
        chk("arst_a_cnt", 32'(bus_a.chg_cnt), 32'h0);
        chk("arst_b_q", 32'(bus_b.qvec), 32'h0);
        chk("arst_b_v", 32'(bus_b.qvalid), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(MODE_TIE, 4'h2, 1'b1, 1'b0); tick();
        drive(MODE_PASS, 4'h0, 1'b0, 1'b0); tick();
        chk("tie_q", 32'(bus_a.qvec), 32'hF);
        chk("tie_v", 32'(bus_a.qvalid), 32'h1);
        tick();
        chk("tie_b_q", 32'(bus_b.qvec), 32'hF);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
            tick();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
